pipe_stage_register: RTL
========================

PIPE_STAGE_REGISTER -- requirements
Module: pipe_stage_register

Interface
REQ-001 The block SHALL have parameter WORD_W, default 64, giving the width of the value fields.
REQ-002 The block SHALL have parameter STAT_W, default 3, giving the width of the status code field.
REQ-003 The block SHALL have parameter CNT_W, default 32, giving the width of the event counters.
REQ-004 The block SHALL have parameter BUBBLE_ICODE, default 4'h1 (nop), giving the icode loaded on bubble or reset.
REQ-005 The block SHALL have parameter RNONE, default 4'hF, giving the register ID loaded on bubble or reset.
REQ-006 The block SHALL have parameter STAT_AOK, default 1, giving the status code loaded on bubble or reset.
REQ-007 The block SHALL have these ports:
  - clock  in  1  sole clock; all state updates on the rising edge.
  - reset_n  in  1  reset; synchronous, active-low.
  - stall  in  1  hold the current contents.
  - bubble  in  1  load a nop bubble.
  - e_stat  in  STAT_W  upstream status.
  - e_icode, e_regA, e_regB  in  4 each  upstream instruction code and register IDs.
  - e_valC, e_valP, e_valA, e_valB, e_valE  in  WORD_W each  upstream values.
  - e_cond  in  1  upstream condition flag.
  - m_stat, m_icode, m_regA, m_regB, m_valC, m_valP, m_valA, m_valB, m_valE, m_cond  out  same widths  registered copies of the matching e_* inputs.
  - m_valid  out  1  1 = held slot came from a real upstream load; 0 = bubble or reset slot.
  - stall_count  out  CNT_W  number of stalled cycles.
  - bubble_count  out  CNT_W  number of bubble cycles.
  - ctl_error  out  1  sticky flag: stall and bubble were asserted together.

Function
REQ-008 All outputs SHALL be registered and SHALL update only on the rising edge of clock.
REQ-009 Load: with reset_n=1, stall=0 and bubble=0, every m_* field SHALL take its e_* value on the edge, m_valid SHALL become 1, and the latency SHALL be exactly 1 cycle.
REQ-010 Stall: with reset_n=1 and stall=1, all m_* fields and m_valid SHALL hold their values, and stall_count SHALL increment by 1.
REQ-011 Bubble: with reset_n=1, bubble=1 and stall=0, the block SHALL load the bubble slot and bubble_count SHALL increment by 1.
  - bubble slot: m_icode=BUBBLE_ICODE; m_regA=m_regB=RNONE; all value fields=0; m_cond=0; m_stat=STAT_AOK; m_valid=0.
REQ-012 Conflict: with stall=1 and bubble=1 in the same cycle, stall SHALL win (hold, stall_count+1, bubble_count unchanged) and ctl_error SHALL be set to 1.
REQ-013 ctl_error SHALL remain 1 until reset.
REQ-014 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-015 The block SHALL have no state machine beyond the slot contents, the two counters and ctl_error; the priority order SHALL be reset, then stall, then bubble, then load.
REQ-016 The e_* inputs SHALL be ignored in every cycle that is not a load.

Reset
REQ-017 On a rising edge with reset_n=0, the block SHALL load the bubble slot, clear stall_count, bubble_count and ctl_error to 0, and ignore stall and bubble.
REQ-018 Reset asserted in the middle of a stall sequence SHALL take effect on that edge, and counting SHALL restart from 0 after reset is released.
REQ-019 Reset SHALL NOT increment either counter.
REQ-020 The first load SHALL occur on the first edge with reset_n=1, stall=0 and bubble=0.

Verification
REQ-021 Reset then load: hold reset_n=0 for 2 edges, then release with e_icode=6, e_valE=64'h15 -> after reset m_icode=1, m_regA=F, m_valid=0, counters=0; one edge after release m_icode=6, m_valE=64'h15, m_valid=1.
REQ-022 Stall hold: load e_valA=64'hAA, then apply stall=1 for 3 edges while e_valA=64'hBB -> m_valA stays 64'hAA and stall_count=3.
REQ-023 Bubble: load e_icode=5, then apply bubble=1 for 1 edge -> m_icode=1, m_regA=m_regB=F, m_valE=0, m_stat=1, m_valid=0, bubble_count=1.
REQ-024 Conflict: assert stall=1 and bubble=1 together for 1 edge, then deassert both -> contents held, stall_count+1, bubble_count unchanged, ctl_error=1 and stays 1 until reset.
REQ-025 Saturation: with CNT_W=3, apply stall=1 for 10 edges -> stall_count=7.
REQ-026 Reset mid-stall: during stall=1 pulse reset_n=0 for 1 edge -> bubble slot loaded and stall_count=0 on that edge.

Source files
------------

// File: rtl/pipe_stage_register.sv
// Pipeline stage register between execute and memory stages.
// Holds one instruction slot (status, icode, register IDs, values, condition)
// with stall/bubble control, saturating stall and bubble event counters, and
// a sticky flag for the illegal stall+bubble combination.
//
// Slot semantics: m_valid=1 means the held slot was loaded from the upstream
// e_* inputs on a load edge; m_valid=0 means the slot is a bubble (nop)
// inserted either by bubble or by reset. A stall keeps m_valid unchanged
// together with the rest of the slot.
module pipe_stage_register #(
    parameter int                WORD_W       = 64,
    parameter int                STAT_W       = 3,
    parameter int                CNT_W        = 32,
    parameter logic [3:0]        BUBBLE_ICODE = 4'h1,
    parameter logic [3:0]        RNONE        = 4'hF,
    parameter logic [STAT_W-1:0] STAT_AOK     = STAT_W'(1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              bubble,
    input  logic [STAT_W-1:0] e_stat,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_regA,
    input  logic [3:0]        e_regB,
    input  logic [WORD_W-1:0] e_valC,
    input  logic [WORD_W-1:0] e_valP,
    input  logic [WORD_W-1:0] e_valA,
    input  logic [WORD_W-1:0] e_valB,
    input  logic [WORD_W-1:0] e_valE,
    input  logic              e_cond,
    output logic [STAT_W-1:0] m_stat,
    output logic [3:0]        m_icode,
    output logic [3:0]        m_regA,
    output logic [3:0]        m_regB,
    output logic [WORD_W-1:0] m_valC,
    output logic [WORD_W-1:0] m_valP,
    output logic [WORD_W-1:0] m_valA,
    output logic [WORD_W-1:0] m_valB,
    output logic [WORD_W-1:0] m_valE,
    output logic              m_cond,
    output logic              m_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count,
    output logic              ctl_error
);

    // Priority is reset, stall, bubble, load. Reset also loads the bubble slot.
    logic load_bubble;
    logic hold_slot;
    logic count_stall;
    logic count_bubble;

    // Decode the control inputs into one action per edge.
    always_comb begin
        hold_slot    = reset_n && stall;
        load_bubble  = !reset_n || (!stall && bubble);
        count_stall  = reset_n && stall && (stall_count != '1);
        count_bubble = reset_n && !stall && bubble && (bubble_count != '1);
    end

    // Slot contents: bubble slot, hold, or capture of the upstream fields.
    always_ff @(posedge clock) begin
        if (load_bubble) begin
            m_stat  <= STAT_AOK;
            m_icode <= BUBBLE_ICODE;
            m_regA  <= RNONE;
            m_regB  <= RNONE;
            m_valC  <= '0;
            m_valP  <= '0;
            m_valA  <= '0;
            m_valB  <= '0;
            m_valE  <= '0;
            m_cond  <= 1'b0;
            m_valid <= 1'b0;
        end else if (!hold_slot) begin
            m_stat  <= e_stat;
            m_icode <= e_icode;
            m_regA  <= e_regA;
            m_regB  <= e_regB;
            m_valC  <= e_valC;
            m_valP  <= e_valP;
            m_valA  <= e_valA;
            m_valB  <= e_valB;
            m_valE  <= e_valE;
            m_cond  <= e_cond;
            m_valid <= 1'b1;
        end
    end

    // Saturating event counters and the sticky stall+bubble conflict flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count  <= '0;
            bubble_count <= '0;
            ctl_error    <= 1'b0;
        end else begin
            if (count_stall) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (count_bubble) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
            if (stall && bubble) begin
                ctl_error <= 1'b1;
            end
        end
    end

endmodule
